// File: rtl/data_cache_pkg.sv
// Shared types and geometry helpers for the direct-mapped write-through data cache.
package data_cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    WDONE = 2'd3
  } state_t;

  function automatic int idx_width(input int nlines);
    return $clog2(nlines);
  endfunction

  function automatic int tag_width(input int nbits, input int nlines);
    return nbits - 2 - $clog2(nlines);
  endfunction

endpackage

// File: rtl/data_cache_sat_counter.sv
// Saturating event counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset)
      count <= '0;
    else if (inc && (count != {W{1'b1}}))
      count <= count + {{(W-1){1'b0}}, 1'b1};
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate cache with one-word lines.
// Stalls the CPU on load misses and on every store while the backing RAM handshake completes.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int NBITS  = 8,
  parameter int NLINES = 4,
  parameter int CNTW   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cpu_rd,
  input  logic             cpu_wr,
  input  logic [NBITS-3:0] cpu_addr,
  input  logic [NBITS-1:0] cpu_wdata,
  output logic [NBITS-1:0] cpu_rdata,
  output logic             stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [NBITS-3:0] mem_addr,
  output logic [NBITS-1:0] mem_wdata,
  input  logic [NBITS-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic [CNTW-1:0]  hit_cnt,
  output logic [CNTW-1:0]  miss_cnt
);

  localparam int AW   = NBITS - 2;
  localparam int IDXW = idx_width(NLINES);
  localparam int TAGW = tag_width(NBITS, NLINES);

  state_t r_state;
  state_t w_next;

  logic [NLINES-1:0] r_valid;
  logic [TAGW-1:0]   r_tag  [NLINES];
  logic [NBITS-1:0]  r_data [NLINES];
  logic              r_fill_done;
  logic [AW-1:0]     r_mem_addr;
  logic [NBITS-1:0]  r_mem_wdata;

  logic [IDXW-1:0] w_idx;
  logic [TAGW-1:0] w_tag;
  logic            w_hit;
  logic [IDXW-1:0] w_lidx;
  logic [TAGW-1:0] w_ltag;
  logic            w_lhit;

  logic w_latch_addr;
  logic w_latch_wdata;
  logic w_hit_inc;
  logic w_miss_inc;
  logic w_fill;
  logic w_wupd;

  assign w_idx  = cpu_addr[IDXW-1:0];
  assign w_tag  = cpu_addr[AW-1:IDXW];
  assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_lidx = r_mem_addr[IDXW-1:0];
  assign w_ltag = r_mem_addr[AW-1:IDXW];
  assign w_lhit = r_valid[w_lidx] && (r_tag[w_lidx] == w_ltag);

  assign cpu_rdata = r_data[w_idx];
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  always_ff @(posedge clock) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    stall         = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    w_latch_addr  = 1'b0;
    w_latch_wdata = 1'b0;
    w_hit_inc     = 1'b0;
    w_miss_inc    = 1'b0;
    w_fill        = 1'b0;
    w_wupd        = 1'b0;
    case (r_state)
      IDLE: begin
        if (cpu_wr) begin
          stall         = 1'b1;
          w_latch_addr  = 1'b1;
          w_latch_wdata = 1'b1;
          w_next        = WRITE;
        end else if (cpu_rd) begin
          if (w_hit) begin
            // The held load that follows a fill is not a fresh hit.
            w_hit_inc = ~r_fill_done;
          end else begin
            stall        = 1'b1;
            w_latch_addr = 1'b1;
            w_miss_inc   = 1'b1;
            w_next       = FILL;
          end
        end
      end
      FILL: begin
        mem_req = 1'b1;
        stall   = 1'b1;
        if (mem_ack) begin
          w_fill = 1'b1;
          w_next = IDLE;
        end
      end
      WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        stall   = 1'b1;
        if (mem_ack) begin
          w_wupd = w_lhit;
          w_next = WDONE;
        end
      end
      WDONE: begin
        // Store retires here; returning to IDLE unconditionally keeps the held cpu_wr from reissuing.
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid     <= '0;
      r_fill_done <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      if (w_fill)
        r_valid[w_lidx] <= 1'b1;
      if (w_fill)
        r_fill_done <= 1'b1;
      else if (r_state == IDLE)
        r_fill_done <= 1'b0;
      if (w_latch_addr)
        r_mem_addr <= cpu_addr;
      if (w_latch_wdata)
        r_mem_wdata <= cpu_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (w_fill) begin
      r_data[w_lidx] <= mem_rdata;
      r_tag[w_lidx]  <= w_ltag;
    end else if (w_wupd) begin
      r_data[w_lidx] <= r_mem_wdata;
    end
  end

  sat_counter #(.W(CNTW)) u_hit_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (w_hit_inc),
    .count (hit_cnt)
  );

  sat_counter #(.W(CNTW)) u_miss_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (w_miss_inc),
    .count (miss_cnt)
  );

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache with a backing RAM that acks 3 cycles after a request.
module tb_data_cache;

  logic       clock;
  logic       reset;
  logic       cpu_rd;
  logic       cpu_wr;
  logic [5:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       stall;
  logic       mem_req;
  logic       mem_we;
  logic [5:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  logic [7:0] hit_cnt;
  logic [7:0] miss_cnt;

  logic       ram_en;
  logic       force_ack;
  logic       r_ack;
  logic [7:0] r_rdata;
  logic [1:0] r_cnt;
  logic [7:0] ram [64];

  int vectors;
  int fails;
  int ncyc;

  data_cache #(.NBITS(8), .NLINES(4), .CNTW(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign mem_ack   = r_ack | force_ack;
  assign mem_rdata = r_rdata;

  // RAM model: ack pulses on the third edge after mem_req is first seen.
  always @(posedge clock) begin
    r_ack <= 1'b0;
    if (reset) begin
      r_cnt   <= 2'd0;
      r_rdata <= 8'h00;
      for (int i = 0; i < 64; i++) ram[i] <= 8'(i) ^ 8'h5A;
      ram[5] <= 8'h3C;
    end else if (!ram_en || !mem_req || r_ack) begin
      r_cnt <= 2'd0;
    end else if (r_cnt == 2'd2) begin
      r_ack <= 1'b1;
      r_cnt <= 2'd0;
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        r_rdata       <= ram[mem_addr];
    end else begin
      r_cnt <= r_cnt + 2'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [5:0] addr, input logic [7:0] wd);
    cpu_rd    = rd;
    cpu_wr    = wr;
    cpu_addr  = addr;
    cpu_wdata = wd;
  endtask

  // Edges until stall drops, bounded so a stuck DUT still reaches the summary.
  task automatic wait_done(output int n);
    n = 0;
    #1;
    while (stall !== 1'b0 && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
  endtask

  task automatic retire();
    @(posedge clock);
    #1;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
  endtask

  initial begin
    vectors   = 0;
    fails     = 0;
    reset     = 1'b1;
    ram_en    = 1'b1;
    force_ack = 1'b0;
    issue(1'b0, 1'b0, 6'h00, 8'h00);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("rst_stall", stall, 0);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_hit", hit_cnt, 0);
    check("rst_miss", miss_cnt, 0);

    // Cold load of 0x05
    @(posedge clock); #1;
    issue(1'b1, 1'b0, 6'h05, 8'h00);
    #1;
    check("cold_stall_idle", stall, 1);
    @(posedge clock); #1;
    check("cold_req", mem_req, 1);
    check("cold_we", mem_we, 0);
    check("cold_addr", mem_addr, 6'h05);
    check("cold_stall", stall, 1);
    wait_done(ncyc);
    check("cold_cycles", ncyc, 4);
    check("cold_rdata", cpu_rdata, 8'h3C);
    retire();
    check("cold_miss", miss_cnt, 1);
    check("cold_hit", hit_cnt, 0);

    // Repeat load hits in the same cycle
    issue(1'b1, 1'b0, 6'h05, 8'h00);
    wait_done(ncyc);
    check("rep_cycles", ncyc, 0);
    check("rep_req", mem_req, 0);
    check("rep_rdata", cpu_rdata, 8'h3C);
    retire();
    check("rep_hit", hit_cnt, 1);

    // Conflict on index 1
    issue(1'b1, 1'b0, 6'h09, 8'h00);
    wait_done(ncyc);
    check("conf_cycles", ncyc, 5);
    check("conf_rdata", cpu_rdata, 8'h53);
    retire();
    issue(1'b1, 1'b0, 6'h05, 8'h00);
    wait_done(ncyc);
    check("evict_cycles", ncyc, 5);
    check("evict_rdata", cpu_rdata, 8'h3C);
    retire();
    check("evict_miss", miss_cnt, 3);
    check("evict_hit", hit_cnt, 1);

    // Store hit
    issue(1'b0, 1'b1, 6'h05, 8'hA7);
    @(posedge clock); #1;
    check("sthit_we", mem_we, 1);
    check("sthit_wdata", mem_wdata, 8'hA7);
    wait_done(ncyc);
    check("sthit_cycles", ncyc, 4);
    check("wdone_req", mem_req, 0);
    @(posedge clock); #1;
    check("wdone_once", dut.r_state == 2'd0, 1);
    cpu_wr = 1'b0;
    check("sthit_ram", ram[5], 8'hA7);
    issue(1'b1, 1'b0, 6'h05, 8'h00);
    wait_done(ncyc);
    check("sthit_rd_cycles", ncyc, 0);
    check("sthit_rdata", cpu_rdata, 8'hA7);
    retire();
    check("sthit_hit", hit_cnt, 2);

    // Store miss: no allocation
    issue(1'b0, 1'b1, 6'h22, 8'h11);
    wait_done(ncyc);
    check("stmiss_cycles", ncyc, 5);
    retire();
    check("stmiss_ram", ram[6'h22], 8'h11);
    issue(1'b1, 1'b0, 6'h22, 8'h00);
    wait_done(ncyc);
    check("stmiss_rd_cycles", ncyc, 5);
    check("stmiss_rdata", cpu_rdata, 8'h11);
    retire();
    check("stmiss_miss", miss_cnt, 4);

    // Reset in the middle of a fill; late ack ignored
    ram_en = 1'b0;
    issue(1'b1, 1'b0, 6'h0D, 8'h00);
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("mid_req", mem_req, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset  = 1'b0;
    cpu_rd = 1'b0;
    ram_en = 1'b1;
    #1;
    check("mid_req_off", mem_req, 0);
    check("mid_stall", stall, 0);
    check("mid_miss", miss_cnt, 0);
    check("mid_hit", hit_cnt, 0);
    force_ack = 1'b1;
    @(posedge clock); #1;
    force_ack = 1'b0;
    #1;
    check("late_ack_req", mem_req, 0);
    check("late_ack_stall", stall, 0);
    issue(1'b1, 1'b0, 6'h05, 8'h00);
    wait_done(ncyc);
    check("post_rst_cycles", ncyc, 5);
    check("post_rst_rdata", cpu_rdata, 8'h3C);
    retire();
    check("post_rst_miss", miss_cnt, 1);
    check("post_rst_hit", hit_cnt, 0);

    // Saturation of the hit counter
    issue(1'b1, 1'b0, 6'h05, 8'h00);
    repeat (254) @(posedge clock);
    #1;
    check("sat_254", hit_cnt, 254);
    repeat (46) @(posedge clock);
    #1;
    check("sat_300", hit_cnt, 255);
    check("sat_miss", miss_cnt, 1);
    cpu_rd = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Small direct-mapped, write-through, no-write-allocate data cache.
- Sits directly downstream of the single-cycle datapath. It consumes the datapath's word address and store data, and returns load data.
- Toward the CPU it stalls while misses and stores complete. Toward a slow backing RAM it uses a req/ack handshake.
- Lines are one word each; tag, valid and data are held in flops.

Parameters:
- NBITS, 8, data width; CPU word address is NBITS-2 bits.
- NLINES, 4, number of cache lines; power of two, at least 2.
- CNTW, 8, width of the hit/miss statistics counters.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- cpu_rd  in  1  load request, held until stall=0
- cpu_wr  in  1  store request, held until stall=0
- cpu_addr  in  NBITS-2  word address (datapath Address[NBITS-1:2])
- cpu_wdata  in  NBITS  store data
- cpu_rdata  out  NBITS  load data; valid when cpu_rd=1 and stall=0
- stall  out  1  CPU must hold its request and not advance
- mem_req  out  1  backing-RAM request
- mem_we  out  1  1=write, 0=read; valid with mem_req
- mem_addr  out  NBITS-2  latched request address
- mem_wdata  out  NBITS  latched store data
- mem_rdata  in  NBITS  RAM read data; valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse from RAM
- hit_cnt  out  CNTW  completed load hits, saturating
- miss_cnt  out  CNTW  load misses, saturating

Behaviour:
- Address split: idx = cpu_addr[log2(NLINES)-1:0]; tag = remaining upper bits. hit = valid[idx] && tag_q[idx]==tag.
- FSM states: IDLE, FILL, WRITE, WDONE. mem_req, mem_we and stall are Moore/combinational decodes of state plus inputs. mem_addr and mem_wdata are registers.
- IDLE, cpu_wr=1:
  - stall=1.
  - Latch addr and wdata into mem_addr and mem_wdata.
  - Go to WRITE.
  - cpu_wr has priority when cpu_rd=1 in the same cycle.
- IDLE, cpu_rd=1, hit:
  - stall=0.
  - cpu_rdata = data_q[idx], combinationally, in the same cycle.
  - Stay in IDLE.
- IDLE, cpu_rd=1, miss:
  - stall=1.
  - Latch addr.
  - Increment miss_cnt.
  - Go to FILL.
- IDLE, no request: stall=0; cpu_rdata = data_q[idx].
- FILL:
  - mem_req=1, mem_we=0, stall=1.
  - On mem_ack: write data_q, tag_q and valid for the latched index; set fill_done; go to IDLE.
  - The load then completes as a hit in the next cycle. Minimum miss latency = ack wait + 2 cycles.
- WRITE:
  - mem_req=1, mem_we=1, stall=1.
  - On mem_ack: if the latched address hits, update data_q of that line; otherwise leave the cache unchanged (no allocate). Go to WDONE.
- WDONE: stall=0 (the store completes this cycle). Go to IDLE unconditionally, which prevents the held cpu_wr from reissuing.
- hit_cnt:
  - Increments on an IDLE load hit with fill_done=0.
  - fill_done clears on any IDLE cycle.
  - The post-fill completion is therefore not counted as a hit.
- Counters saturate at 2^CNTW-1 and never wrap.
- mem_ack outside FILL/WRITE is ignored. mem_rdata is sampled only when mem_ack=1 in FILL.
- The RAM may take any number of cycles to ack; the cache waits indefinitely, and mem_req stays high and stable until ack.
- Reset, including mid-FILL or mid-WRITE:
  - state=IDLE; all valid=0; counters=0; fill_done=0; mem_addr=0; mem_wdata=0.
  - mem_req=0 and mem_we=0 in the cycle after reset is sampled; stall=0 when no request.
  - data_q and tag_q need not be reset.
- cpu_addr and cpu_wdata must be stable while stall=1; the cache uses latched copies regardless.

Decomposition:
- Package data_cache_pkg:
  - state enum {IDLE, FILL, WRITE, WDONE}.
  - Functions/constants for IDXW = $clog2(NLINES) and TAGW = NBITS-2-IDXW.
- Sub-module sat_counter (parameter W; inputs inc, reset; output count) is instantiated twice, for hits and misses.
- Tag/data/valid arrays stay inline.

Test Plan (NBITS=8, NLINES=4; bench RAM acks 3 cycles after req; RAM[0x05]=0x3C):
- Cold load: rd addr=0x05 after reset -> stall=1 and mem_req=1, mem_we=0, mem_addr=0x05 until ack. stall=0 two cycles after ack with cpu_rdata=0x3C. miss_cnt=1, hit_cnt=0.
- Repeat load: rd 0x05 again -> stall=0 the same cycle, cpu_rdata=0x3C, no mem_req, hit_cnt=1.
- Conflict eviction: rd 0x09 (same idx 1, different tag) -> miss and fill. Subsequent rd 0x05 misses again; miss_cnt=3.
- Store hit: wr 0x05 with data 0xA7 -> stall for the ack period, mem_we=1, mem_wdata=0xA7. stall=0 for exactly one WDONE cycle. Next rd 0x05 hits with 0xA7.
- Store miss: wr 0x22 with data 0x11 -> RAM written. Next rd 0x22 misses, showing no allocation.
- Reset mid-FILL: assert reset while in FILL before ack -> mem_req=0 next cycle; a late ack is ignored. rd 0x05 then misses (valid cleared) and counters restart from 0. Also check saturation: force 300 hits -> hit_cnt stays 255.
